// File: rtl/tc_pkg.sv
// Shared definitions for the thermocouple scan scheduler: FSM state
// encoding, 32-bit frame field positions and the fault_bits codes.
package tc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CONV = 3'd1,
        ST_REQ  = 3'd2,
        ST_XFER = 3'd3,
        ST_CAPT = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

    localparam int unsigned CNT_W     = 16;

    localparam int unsigned FRAME_W   = 32;
    localparam int unsigned TC_MSB    = 31;
    localparam int unsigned TC_LSB    = 18;
    localparam int unsigned FAULT_BIT = 16;
    localparam int unsigned JT_MSB    = 15;
    localparam int unsigned JT_LSB    = 4;
    localparam int unsigned FLT_MSB   = 2;
    localparam int unsigned FLT_LSB   = 0;

    localparam int unsigned TC_W      = TC_MSB - TC_LSB + 1;
    localparam int unsigned JT_W      = JT_MSB - JT_LSB + 1;
    localparam int unsigned FB_W      = 4;

    // fault_bits = {frame fault flag, open/short-gnd/short-vcc}; the
    // timeout code sets only the MSB with the detail bits clear.
    localparam logic [FB_W-1:0] FB_TIMEOUT = 4'b1000;

endpackage

// File: rtl/tc_frame_decode.sv
// Combinational field extraction from one 32-bit thermocouple frame.
import tc_pkg::*;

module tc_frame_decode (
    input  logic [FRAME_W-1:0] frame,
    output logic [TC_W-1:0]    tc_temp,
    output logic [JT_W-1:0]    junction_temp,
    output logic [FB_W-1:0]    fault_bits,
    output logic               any_fault
);

    // Slice temperature and fault fields out of the raw frame
    always_comb begin
        tc_temp       = frame[TC_MSB:TC_LSB];
        junction_temp = frame[JT_MSB:JT_LSB];
        fault_bits    = {frame[FAULT_BIT], frame[FLT_MSB:FLT_LSB]};
        any_fault     = |fault_bits;
    end

    // Reserved frame bits are intentionally ignored
    logic unused_frame_bits;
    assign unused_frame_bits = ^{frame[17], frame[3]};

endmodule

// File: rtl/tc_scan_scheduler.sv
// Round-robin scan scheduler for NUM_CH thermocouple converters sharing
// one SPI master. Optional feature: define TC_SCAN_TIMEOUT_EN to abandon
// a read that does not complete within TIMEOUT_CYCLES clocks.
import tc_pkg::*;

module tc_scan_scheduler #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CONV_CYCLES    = 18000,
    parameter int unsigned GAP_CYCLES     = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic              spi_not_busy,
    input  logic [31:0]       spi_rx_data,
    output logic              spi_ena,
    output logic [NUM_CH-1:0] cs_n,
    output logic [2:0]        ch_idx,
    output logic [13:0]       tc_temp_data,
    output logic [11:0]       junction_temp_data,
    output logic [3:0]        fault_bits,
    output logic              data_valid,
    output logic [NUM_CH-1:0] fault_map
);

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         ch;
    logic [2:0]         ch_nxt;
    logic [NUM_CH-1:0]  ch_mask;
    logic [NUM_CH-1:0]  sel_first;
    logic [NUM_CH-1:0]  sel_next;

    logic [TC_W-1:0]    dec_tc;
    logic [JT_W-1:0]    dec_jt;
    logic [FB_W-1:0]    dec_fb;
    logic               dec_any;

    tc_frame_decode u_decode (
        .frame         (spi_rx_data),
        .tc_temp       (dec_tc),
        .junction_temp (dec_jt),
        .fault_bits    (dec_fb),
        .any_fault     (dec_any)
    );

    // Next channel (wrapping) and the active-low selects derived from it
    always_comb begin
        ch_nxt    = (ch == 3'(NUM_CH - 1)) ? 3'd0 : ch + 3'd1;
        ch_mask   = NUM_CH'(1) << ch;
        sel_first = ~NUM_CH'(1);
        sel_next  = ~(NUM_CH'(1) << ch_nxt);
    end

`ifndef TC_SCAN_TIMEOUT_EN
    logic unused_tmo;
    assign unused_tmo = ^TMO_LAST;
`endif

    // Scan FSM with registered SPI control, chip selects and result outputs.
    // Outputs belonging to a state are loaded on the edge that enters it, so
    // the CAPT results are loaded on the XFER->CAPT edge and are visible
    // during CAPT, one clock after spi_not_busy returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            ch                 <= '0;
            spi_ena            <= 1'b0;
            cs_n               <= '1;
            ch_idx             <= '0;
            tc_temp_data       <= '0;
            junction_temp_data <= '0;
            fault_bits         <= '0;
            data_valid         <= 1'b0;
            fault_map          <= '0;
        end else begin
            data_valid <= 1'b0;
`ifdef TC_SCAN_TIMEOUT_EN
            if ((state == ST_REQ || state == ST_XFER) && cnt == TMO_LAST) begin
                spi_ena    <= 1'b0;
                cs_n       <= '1;
                fault_bits <= FB_TIMEOUT;
                fault_map  <= fault_map | ch_mask;
                ch_idx     <= ch;
                data_valid <= 1'b1;
                cnt        <= '0;
                state      <= ST_GAP;
            end else begin
                if (state == ST_REQ || state == ST_XFER)
                    cnt <= cnt + 1'b1;
`endif
                case (state)
                    ST_IDLE: begin
                        spi_ena <= 1'b0;
                        cs_n    <= '1;
                        cnt     <= '0;
                        if (scan_en)
                            state <= ST_CONV;
                    end
                    ST_CONV: begin
                        if (!scan_en) begin
                            state <= ST_IDLE;
                        end else if (cnt == CONV_LAST) begin
                            ch      <= '0;
                            cs_n    <= sel_first;
                            spi_ena <= 1'b1;
                            cnt     <= '0;
                            state   <= ST_REQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (!spi_not_busy) begin
                            spi_ena <= 1'b0;
                            state   <= ST_XFER;
                        end else begin
                            spi_ena <= 1'b1;
                        end
                    end
                    ST_XFER: begin
                        if (spi_not_busy) begin
                            tc_temp_data       <= dec_tc;
                            junction_temp_data <= dec_jt;
                            fault_bits         <= dec_fb;
                            fault_map          <= dec_any ? (fault_map | ch_mask)
                                                          : (fault_map & ~ch_mask);
                            ch_idx             <= ch;
                            data_valid         <= 1'b1;
                            cs_n               <= '1;
                            state              <= ST_CAPT;
                        end
                    end
                    ST_CAPT: begin
                        cnt   <= '0;
                        state <= ST_GAP;
                    end
                    ST_GAP: begin
                        if (!scan_en) begin
                            state <= ST_IDLE;
                        end else if (cnt == GAP_LAST) begin
                            ch      <= ch_nxt;
                            cs_n    <= sel_next;
                            spi_ena <= 1'b1;
                            cnt     <= '0;
                            state   <= ST_REQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        spi_ena <= 1'b0;
                        cs_n    <= '1;
                        cnt     <= '0;
                        state   <= ST_IDLE;
                    end
                endcase
`ifdef TC_SCAN_TIMEOUT_EN
            end
`endif
        end
    end

endmodule

// File: tb/tb_tc_scan_scheduler.sv
// Self-checking bench for tc_scan_scheduler with a behavioural SPI master
// and a scoreboard of expected capture results.
module tb_tc_scan_scheduler;

    logic        clk;
    logic        rst;
    logic        scan_en;
    logic        spi_not_busy;
    logic [31:0] spi_rx_data;
    logic        spi_ena;
    logic [3:0]  cs_n;
    logic [2:0]  ch_idx;
    logic [13:0] tc_temp_data;
    logic [11:0] junction_temp_data;
    logic [3:0]  fault_bits;
    logic        data_valid;
    logic [3:0]  fault_map;

    tc_scan_scheduler #(
        .NUM_CH         (4),
        .CONV_CYCLES    (20),
        .GAP_CYCLES     (10),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .scan_en            (scan_en),
        .spi_not_busy       (spi_not_busy),
        .spi_rx_data        (spi_rx_data),
        .spi_ena            (spi_ena),
        .cs_n               (cs_n),
        .ch_idx             (ch_idx),
        .tc_temp_data       (tc_temp_data),
        .junction_temp_data (junction_temp_data),
        .fault_bits         (fault_bits),
        .data_valid         (data_valid),
        .fault_map          (fault_map)
    );

    typedef struct {
        logic [31:0] frame;
        logic        tmo;
        logic [2:0]  ch;
        logic [13:0] tc;
        logic [11:0] jt;
        logic [3:0]  fb;
        logic [3:0]  fm;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] frames_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_dv    = 0;
    int          cyc     = 0;
    int          rise_cyc = 0;
    int          busy_cnt = 0;
    logic        model_stuck = 1'b0;
    logic [1:0]  exp_ch  = 2'd0;
    logic [3:0]  fm_model = 4'd0;
    logic [13:0] last_tc = '0;
    logic [11:0] last_jt = '0;
    logic [31:0] frame_v;
    exp_t        ent;
    exp_t        got_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_dv(input int target, input int budget, input string tag);
        int w = 0;
        while (n_dv < target && w < budget) begin
            @(posedge clk); #2;
            w++;
        end
        check(tag, n_dv, target);
    endtask

    task automatic push_timeout;
        ent.frame = '0;
        ent.tmo   = 1'b1;
        ent.ch    = {1'b0, exp_ch};
        ent.tc    = last_tc;
        ent.jt    = last_jt;
        ent.fb    = 4'b1000;
        fm_model[exp_ch] = 1'b1;
        ent.fm    = fm_model;
        exp_q.push_back(ent);
        exp_ch    = exp_ch + 2'd1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SPI master model: accepts spi_ena, stays busy 8 clocks, then returns a frame
    initial begin
        spi_not_busy = 1'b1;
        spi_rx_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt     = 0;
                spi_not_busy = 1'b1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    spi_not_busy = 1'b1;
                    rise_cyc     = cyc;
                end
            end else if (spi_ena && spi_not_busy && !model_stuck) begin
                frame_v = (frames_q.size() > 0) ? frames_q.pop_front() : $urandom;
                spi_rx_data = frame_v;
                check("cs_select", {28'd0, cs_n}, {28'd0, ~(4'b0001 << exp_ch)});
                ent.frame = frame_v;
                ent.tmo   = 1'b0;
                ent.ch    = {1'b0, exp_ch};
                ent.tc    = frame_v[31:18];
                ent.jt    = frame_v[15:4];
                ent.fb    = {frame_v[16], frame_v[2:0]};
                fm_model[exp_ch] = (ent.fb != 4'd0);
                ent.fm    = fm_model;
                exp_q.push_back(ent);
                last_tc   = ent.tc;
                last_jt   = ent.jt;
                exp_ch    = exp_ch + 2'd1;
                spi_not_busy = 1'b0;
                busy_cnt     = 8;
            end
        end
    end

    // Output monitor: pops the scoreboard on each data_valid strobe
    initial forever begin
        @(negedge clk);
        check("cs_onehot", ($countones(~cs_n) <= 1), 1);
        if (!rst && data_valid) begin
            n_dv++;
            if (exp_q.size() == 0) begin
                check("dv_unexpected", exp_q.size(), 1);
            end else begin
                got_e = exp_q.pop_front();
                if (!got_e.tmo)
                    check("dv_latency", cyc - rise_cyc, 1);
                check("ch_idx", ch_idx, got_e.ch);
                check("tc_temp", tc_temp_data, got_e.tc);
                check("junction", junction_temp_data, got_e.jt);
                check("fault_bits", fault_bits, got_e.fb);
                check("fault_map", fault_map, got_e.fm);
                check("cs_capt_high", cs_n, 4'hF);
                if (got_e.frame == 32'hABCD_1237) begin
                    check("vec_tc", tc_temp_data, 14'h2AF3);
                    check("vec_jt", junction_temp_data, 12'h123);
                end
            end
        end
    end

    initial begin : main
        int w;
        int base;
        int ena_seen;
        int t0;
        rst     = 1'b1;
        scan_en = 1'b0;
        frames_q = '{32'h0000_0000, 32'h0003_0005, 32'hABCD_1237, 32'h0001_0000,
                     32'h8000_FFF8, 32'h7FFF_0002, 32'h1234_5678};

        // reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_spi_ena", spi_ena, 0);
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_ch_idx", ch_idx, 0);
        check("rst_tc", tc_temp_data, 0);
        check("rst_jt", junction_temp_data, 0);
        check("rst_fb", fault_bits, 0);
        check("rst_dv", data_valid, 0);
        check("rst_fm", fault_map, 0);
        rst = 1'b0;

        // continuous scan: ch 0,1,2,3,0,1,2 with the table frames
        @(posedge clk); #2;
        scan_en = 1'b1;
        wait_dv(7, 2000, "scan_reads");

        // drop scan_en while a transfer is in flight
        w = 0;
        while (spi_not_busy && w < 200) begin @(posedge clk); #2; w++; end
        check("xfer_wait", spi_not_busy, 0);
        base = n_dv;
        scan_en = 1'b0;
        wait_dv(base + 1, 100, "drop_completes");
        repeat (3) @(posedge clk);
        #2;
        check("drop_cs_n", cs_n, 4'hF);
        check("drop_spi_ena", spi_ena, 0);
        ena_seen = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (spi_ena) ena_seen++;
        end
        check("drop_idle_ena", ena_seen, 0);
        check("drop_dv_count", n_dv, base + 1);
        check("drop_queue", exp_q.size(), 0);

        // reset pulsed mid-transfer abandons the read
        scan_en = 1'b1;
        w = 0;
        while (spi_not_busy && w < 200) begin @(posedge clk); #2; w++; end
        check("xfer2_wait", spi_not_busy, 0);
        repeat (2) @(posedge clk);
        #2;
        base = n_dv;
        rst = 1'b1;
        exp_q.delete();
        exp_ch   = 2'd0;
        fm_model = 4'd0;
        last_tc  = '0;
        last_jt  = '0;
        #1;
        check("mid_rst_spi_ena", spi_ena, 0);
        check("mid_rst_cs_n", cs_n, 4'hF);
        check("mid_rst_ch_idx", ch_idx, 0);
        check("mid_rst_tc", tc_temp_data, 0);
        check("mid_rst_jt", junction_temp_data, 0);
        check("mid_rst_fb", fault_bits, 0);
        check("mid_rst_dv", data_valid, 0);
        check("mid_rst_fm", fault_map, 0);
        scan_en = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        check("mid_rst_no_dv", n_dv, base);

`ifdef TC_SCAN_TIMEOUT_EN
        // SPI never goes busy: each read times out and scanning moves on
        model_stuck = 1'b1;
        scan_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            base = n_dv;
            w = 0;
            while (!spi_ena && w < 200) begin @(posedge clk); #2; w++; end
            check("tmo_req_wait", spi_ena, 1);
            t0 = cyc;
            check("tmo_cs_n", {28'd0, cs_n}, {28'd0, ~(4'b0001 << exp_ch)});
            push_timeout();
            w = 0;
            while (!data_valid && w < 100) begin @(posedge clk); #2; w++; end
            check("tmo_dv", data_valid, 1);
            check("tmo_cycles", cyc - t0, 16);
            @(posedge clk); #2;
            check("tmo_dv_count", n_dv, base + 1);
        end
        scan_en = 1'b0;
        repeat (5) @(posedge clk);
        #2;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
